// File: rtl/eff_switch_ctrl_pkg.sv
// Shared types for the effect-selection control path.
// Also supplies the select width used by the effect pipeline.
package eff_switch_ctrl_pkg;

    localparam int EFF_SEL_WIDTH = 16;
    localparam int EFF_REQ_WIDTH = EFF_SEL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_DN,
        FLUSH,
        RAMP_UP
    } eff_ctrl_state_t;

endpackage

// File: rtl/eff_switch_debounce.sv
// Two-flop synchroniser and per-sample stability filter
// for the raw switch request word.
module eff_switch_debounce #(
    parameter int WIDTH      = 17,
    parameter int STABLE_LEN = 1024,
    localparam int CW        = $clog2(STABLE_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] cand_o,
    output logic             stable_o
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (tick_i) begin
            if (req_q != cand_q) begin
                cand_d = req_q;
                cnt_d  = '0;
            end else if (cnt_q != CW'(STABLE_LEN)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            req_q  <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= req_i;
            req_q  <= sync_q;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // True when a tick now would bring the count to STABLE_LEN (or it is there).
    assign stable_o = (req_q == cand_q) &&
                      (cnt_q >= CW'(STABLE_LEN - 1));
    assign cand_o   = cand_q;

endmodule

// File: rtl/eff_switch_ctrl.sv
// Click-free effect-selection sequencer: debounced request,
// ramp gain down, swap selection, flush, ramp gain back up.
module eff_switch_ctrl
    import eff_switch_ctrl_pkg::*;
#(
    parameter int RAMP_LEN   = 256,
    parameter int FLUSH_LEN  = 64,
    parameter int STABLE_LEN = 1024,
    parameter int GAIN_WIDTH = $clog2(RAMP_LEN) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_req,
    input  logic [EFF_SEL_WIDTH-1:0] sel_req,
    input  logic                     smp_tick,
    output logic                     en_o,
    output logic [EFF_SEL_WIDTH-1:0] sel_o,
    output logic [GAIN_WIDTH-1:0]    gain_o,
    output logic                     busy_o
);

    localparam int FW = $clog2(FLUSH_LEN + 1);

    eff_ctrl_state_t          state_q, state_d;
    logic [GAIN_WIDTH-1:0]    gain_q, gain_d;
    logic [EFF_REQ_WIDTH-1:0] app_q, app_d;
    logic [EFF_REQ_WIDTH-1:0] pend_q, pend_d;
    logic [FW-1:0]            flush_q, flush_d;
    logic                     busy_q, busy_d;
    logic [EFF_REQ_WIDTH-1:0] cand;
    logic                     stable;

    eff_switch_debounce #(
        .WIDTH      (EFF_REQ_WIDTH),
        .STABLE_LEN (STABLE_LEN)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (smp_tick),
        .req_i    ({en_req, sel_req}),
        .cand_o   (cand),
        .stable_o (stable)
    );

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        app_d   = app_q;
        pend_d  = pend_q;
        flush_d = flush_q;
        if (smp_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (stable && (cand != app_q)) begin
                        pend_d  = cand;
                        state_d = RAMP_DN;
                    end
                end
                RAMP_DN: begin
                    if (gain_q <= GAIN_WIDTH'(1)) begin
                        gain_d  = '0;
                        app_d   = pend_q;
                        flush_d = '0;
                        state_d = FLUSH;
                    end else begin
                        gain_d = gain_q - GAIN_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    flush_d = flush_q + FW'(1);
                    if (flush_q >= FW'(FLUSH_LEN - 1)) begin
                        state_d = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (gain_q >= GAIN_WIDTH'(RAMP_LEN - 1)) begin
                        gain_d  = GAIN_WIDTH'(RAMP_LEN);
                        state_d = IDLE;
                    end else begin
                        gain_d = gain_q + GAIN_WIDTH'(1);
                    end
                end
                default: state_d = RAMP_UP;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAMP_UP;
            gain_q  <= '0;
            app_q   <= '0;
            pend_q  <= '0;
            flush_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            app_q   <= app_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
        end
    end

    assign en_o   = app_q[EFF_REQ_WIDTH-1];
    assign sel_o  = app_q[EFF_SEL_WIDTH-1:0];
    assign gain_o = gain_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_eff_switch_ctrl.sv
// Directed bench for eff_switch_ctrl with short ramps and
// one sample tick every four clocks.
module tb_eff_switch_ctrl;

    logic        clk;
    logic        rst;
    logic        en_req;
    logic [15:0] sel_req;
    logic        smp_tick;
    logic        en_o;
    logic [15:0] sel_o;
    logic [2:0]  gain_o;
    logic        busy_o;

    int n_tests;
    int n_fail;

    eff_switch_ctrl #(
        .RAMP_LEN   (4),
        .FLUSH_LEN  (2),
        .STABLE_LEN (3),
        .GAIN_WIDTH (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_req   (en_req),
        .sel_req  (sel_req),
        .smp_tick (smp_tick),
        .en_o     (en_o),
        .sel_o    (sel_o),
        .gain_o   (gain_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_req(input logic e, input logic [15:0] s);
        @(negedge clk);
        en_req  = e;
        sel_req = s;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        smp_tick = 1'b1;
        repeat (3) @(negedge clk);
        smp_tick = 1'b0;
        n_tests++;
        if (gain_o !== 3'd0 || busy_o !== 1'b1 ||
            en_o !== 1'b0 || sel_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state got g=%0d b=%0b e=%0b s=%h exp g=0 b=1 e=0 s=0000",
                     gain_o, busy_o, en_o, sel_o);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (gain_o !== 3'd0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold_no_tick got g=%0d b=%0b exp g=0 b=1",
                     gain_o, busy_o);
        end
    endtask

    task automatic test_fade_in();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (gain_o !== 3'(i) || busy_o !== (i < 4) ||
                en_o !== 1'b0 || sel_o !== 16'h0) begin
                n_fail++;
                $display("FAIL fade_in_%0d got g=%0d b=%0b e=%0b s=%h exp g=%0d b=%0b e=0 s=0000",
                         i, gain_o, busy_o, en_o, sel_o, i, (i < 4));
            end
        end
    endtask

    task automatic test_single_change();
        set_req(1'b1, 16'h0005);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (busy_o !== (i == 4) || gain_o !== 3'd4) begin
                n_fail++;
                $display("FAIL accept_tick%0d got b=%0b g=%0d exp b=%0b g=4",
                         i, busy_o, gain_o, (i == 4));
            end
        end
        for (int i = 3; i >= 0; i--) begin
            tick();
            n_tests++;
            if (gain_o !== 3'(i)) begin
                n_fail++;
                $display("FAIL ramp_dn_%0d got g=%0d exp %0d", i, gain_o, i);
            end
            n_tests++;
            if (i > 0 && (en_o !== 1'b0 || sel_o !== 16'h0)) begin
                n_fail++;
                $display("FAIL early_swap_%0d got e=%0b s=%h exp e=0 s=0000",
                         i, en_o, sel_o);
            end else if (i == 0 && (en_o !== 1'b1 || sel_o !== 16'h0005)) begin
                n_fail++;
                $display("FAIL swap got e=%0b s=%h exp e=1 s=0005", en_o, sel_o);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (gain_o !== 3'd0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_%0d got g=%0d b=%0b exp g=0 b=1",
                         i, gain_o, busy_o);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (gain_o !== 3'(i) || busy_o !== (i < 4)) begin
                n_fail++;
                $display("FAIL ramp_up_%0d got g=%0d b=%0b exp g=%0d b=%0b",
                         i, gain_o, busy_o, i, (i < 4));
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 10; k++) begin
            set_req(1'b1, sel_req ^ 16'h0001);
            repeat (2) tick();
            n_tests++;
            if (busy_o !== 1'b0 || gain_o !== 3'd4 || sel_o !== 16'h0005) begin
                n_fail++;
                $display("FAIL bounce_%0d got b=%0b g=%0d s=%h exp b=0 g=4 s=0005",
                         k, busy_o, gain_o, sel_o);
            end
        end
    endtask

    task automatic test_same_request();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (busy_o !== 1'b0 || en_o !== 1'b1 || sel_o !== 16'h0005) begin
                n_fail++;
                $display("FAIL same_req_%0d got b=%0b e=%0b s=%h exp b=0 e=1 s=0005",
                         i, busy_o, en_o, sel_o);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        set_req(1'b0, 16'h00A0);
        repeat (4) tick();
        repeat (4) tick();
        tick();
        n_tests++;
        if (gain_o !== 3'd0 || en_o !== 1'b0 || sel_o !== 16'h00A0 ||
            busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_flush got g=%0d e=%0b s=%h b=%0b exp g=0 e=0 s=00a0 b=1",
                     gain_o, en_o, sel_o, busy_o);
        end
        set_req(1'b0, 16'h0000);
        rst      = 1'b1;
        smp_tick = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        smp_tick = 1'b0;
        n_tests++;
        if (gain_o !== 3'd0 || en_o !== 1'b0 || sel_o !== 16'h0 ||
            busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got g=%0d e=%0b s=%h b=%0b exp g=0 e=0 s=0000 b=1",
                     gain_o, en_o, sel_o, busy_o);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (gain_o !== 3'(i) || busy_o !== (i < 4)) begin
                n_fail++;
                $display("FAIL refade_%0d got g=%0d b=%0b exp g=%0d b=%0b",
                         i, gain_o, busy_o, i, (i < 4));
            end
        end
    endtask

    task automatic test_change_during_transition();
        int n;
        set_req(1'b1, 16'h0005);
        repeat (4) tick();
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL trans_start got b=%0b exp 1", busy_o);
        end
        tick();
        set_req(1'b1, 16'h0008);
        repeat (3) tick();
        n_tests++;
        if (gain_o !== 3'd0 || en_o !== 1'b1 || sel_o !== 16'h0005) begin
            n_fail++;
            $display("FAIL trans_first_swap got g=%0d e=%0b s=%h exp g=0 e=1 s=0005",
                     gain_o, en_o, sel_o);
        end
        repeat (6) tick();
        n_tests++;
        if (busy_o !== 1'b0 || gain_o !== 3'd4 || sel_o !== 16'h0005) begin
            n_fail++;
            $display("FAIL trans_first_done got b=%0b g=%0d s=%h exp b=0 g=4 s=0005",
                     busy_o, gain_o, sel_o);
        end
        tick();
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL trans_second_start got b=%0b exp 1", busy_o);
        end
        n = 0;
        while (busy_o === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== 10) begin
            n_fail++;
            $display("FAIL trans_second_len got %0d ticks exp 10", n);
        end
        n_tests++;
        if (busy_o !== 1'b0 || gain_o !== 3'd4 ||
            en_o !== 1'b1 || sel_o !== 16'h0008) begin
            n_fail++;
            $display("FAIL trans_second_done got b=%0b g=%0d e=%0b s=%h exp b=0 g=4 e=1 s=0008",
                     busy_o, gain_o, en_o, sel_o);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en_req   = 1'b0;
        sel_req  = 16'h0;
        smp_tick = 1'b0;
        test_reset();
        test_fade_in();
        test_single_change();
        test_bounce();
        test_same_request();
        test_reset_mid_flush();
        test_change_during_transition();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
